// File: rtl/json_byte_lexer.sv
// json_byte_lexer: streaming JSON tokenizer. Turns a raw byte stream into
// tagged token beats for the downstream decoder. It checks bracket nesting,
// literals, control characters inside strings and payload length. Number
// grammar and \u decoding are left to the decoder.
//
// Handshake: a byte moves when in_valid && in_ready, and a beat moves when
// out_valid && out_ready. A held beat stays stable until it is taken.
// in_ready normally tracks free output space (!out_valid || out_ready).
// It is forced to 1 in ERR, where bytes are dropped. It is forced to 0 in
// FLUSH. In NUM it is 0 for a byte that ends the number.
module json_byte_lexer #(
  parameter int MAX_TOKEN_LEN = 64,
  parameter int NESTING_DEPTH = 16,
  localparam int DW = $clog2(NESTING_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_kind,
  output logic [7:0]    out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_empty,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [DW-1:0] depth
);

  localparam int CW = $clog2(MAX_TOKEN_LEN + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STR   = 3'd1;
  localparam logic [2:0] S_ESC   = 3'd2;
  localparam logic [2:0] S_NUM   = 3'd3;
  localparam logic [2:0] S_LIT   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
  localparam logic [2:0] S_FLUSH = 3'd6;

  localparam logic [3:0] K_LBRACE = 4'd0;
  localparam logic [3:0] K_RBRACE = 4'd1;
  localparam logic [3:0] K_LBRACK = 4'd2;
  localparam logic [3:0] K_RBRACK = 4'd3;
  localparam logic [3:0] K_COLON  = 4'd4;
  localparam logic [3:0] K_COMMA  = 4'd5;
  localparam logic [3:0] K_STRING = 4'd6;
  localparam logic [3:0] K_NUMBER = 4'd7;
  localparam logic [3:0] K_TRUE   = 4'd8;
  localparam logic [3:0] K_FALSE  = 4'd9;
  localparam logic [3:0] K_NULL   = 4'd10;
  localparam logic [3:0] K_EOD    = 4'd11;
  localparam logic [3:0] K_ERROR  = 4'd15;

  // Registered state
  logic [2:0]               state_q, state_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [7:0]               pend_data_q, pend_data_d;
  logic                     pend_first_q, pend_first_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               lit_sel_q, lit_sel_d;
  logic [2:0]               lit_idx_q, lit_idx_d;
  logic [DW-1:0]            depth_q, depth_d;
  logic [NESTING_DEPTH-1:0] stack_q, stack_d;   // bit0 is top of stack; 1 = '['
  logic                     err_q, err_d;
  logic [2:0]               err_code_q, err_code_d;
  logic                     unterm_q, unterm_d;  // document ended inside a token or nesting
  logic                     out_valid_q, out_valid_d;
  logic [3:0]               out_kind_q, out_kind_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;
  logic                     out_empty_q, out_empty_d;

  // Per-cycle decisions
  logic       slot, fire;
  logic       emit, e_sop, e_eop, e_empty;
  logic [3:0] e_kind;
  logic [7:0] e_data;
  logic       take, raise, want_brk;
  logic [2:0] raise_code;

  function automatic logic is_num_class(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || b == 8'h2D || b == 8'h2B ||
           b == 8'h2E || b == 8'h65 || b == 8'h45;
  endfunction

  function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case ({sel, idx})
      5'b00_001: c = 8'h72;  // tRue
      5'b00_010: c = 8'h75;  // trUe
      5'b00_011: c = 8'h65;  // truE
      5'b01_001: c = 8'h61;  // fAlse
      5'b01_010: c = 8'h6C;  // faLse
      5'b01_011: c = 8'h73;  // falSe
      5'b01_100: c = 8'h65;  // falsE
      5'b10_001: c = 8'h75;  // nUll
      5'b10_010: c = 8'h6C;  // nuLl
      5'b10_011: c = 8'h6C;  // nulL
      default:   c = 8'h00;
    endcase
    return c;
  endfunction

  assign slot = !out_valid_q || out_ready;

  // Byte acceptance depends on state: drop freely in ERR, hold off in FLUSH,
  // refuse a number terminator so IDLE can re-evaluate it next cycle.
  always_comb begin
    case (state_q)
      S_ERR:   in_ready = 1'b1;
      S_FLUSH: in_ready = 1'b0;
      S_NUM:   in_ready = slot && is_num_class(in_data);
      default: in_ready = slot;
    endcase
  end

  assign fire = in_valid && in_ready;

  // Next-state, token, stack and output-beat computation
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_first_d = pend_first_q;
    cnt_d        = cnt_q;
    lit_sel_d    = lit_sel_q;
    lit_idx_d    = lit_idx_q;
    depth_d      = depth_q;
    stack_d      = stack_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    unterm_d     = unterm_q;
    out_valid_d  = out_valid_q;
    out_kind_d   = out_kind_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    emit         = 1'b0;
    e_kind       = K_EOD;
    e_data       = 8'h00;
    e_sop        = 1'b1;
    e_eop        = 1'b1;
    e_empty      = 1'b0;
    take         = 1'b0;
    raise        = 1'b0;
    raise_code   = 3'd0;
    want_brk     = (in_data == 8'h5D);

    // The error flag lives until the end-of-document beat is taken.
    if (out_valid_q && out_ready && out_kind_q == K_EOD) begin
      err_d      = 1'b0;
      err_code_d = 3'd0;
    end

    case (state_q)
      S_IDLE: if (fire) begin
        case (in_data)
          8'h20, 8'h09, 8'h0A, 8'h0D: ;
          8'h7B, 8'h5B: begin
            if (depth_q == DW'(NESTING_DEPTH)) begin
              raise = 1'b1; raise_code = 3'd3;
            end else begin
              stack_d = {stack_q[NESTING_DEPTH-2:0], (in_data == 8'h5B)};
              depth_d = depth_q + DW'(1);
              emit    = 1'b1;
              e_kind  = (in_data == 8'h5B) ? K_LBRACK : K_LBRACE;
              e_data  = in_data;
            end
          end
          8'h7D, 8'h5D: begin
            if (depth_q == '0 || stack_q[0] != want_brk) begin
              raise = 1'b1; raise_code = 3'd4;
            end else begin
              stack_d = {1'b0, stack_q[NESTING_DEPTH-1:1]};
              depth_d = depth_q - DW'(1);
              emit    = 1'b1;
              e_kind  = want_brk ? K_RBRACK : K_RBRACE;
              e_data  = in_data;
            end
          end
          8'h3A: begin emit = 1'b1; e_kind = K_COLON; e_data = in_data; end
          8'h2C: begin emit = 1'b1; e_kind = K_COMMA; e_data = in_data; end
          8'h22: begin
            state_d      = S_STR;
            pend_valid_d = 1'b0;
            pend_first_d = 1'b1;
            cnt_d        = '0;
          end
          8'h74: begin state_d = S_LIT; lit_sel_d = 2'd0; lit_idx_d = 3'd1; end
          8'h66: begin state_d = S_LIT; lit_sel_d = 2'd1; lit_idx_d = 3'd1; end
          8'h6E: begin state_d = S_LIT; lit_sel_d = 2'd2; lit_idx_d = 3'd1; end
          default: begin
            if (in_data == 8'h2D || (in_data >= 8'h30 && in_data <= 8'h39)) begin
              state_d      = S_NUM;
              pend_valid_d = 1'b1;
              pend_data_d  = in_data;
              pend_first_d = 1'b1;
              cnt_d        = CW'(1);
            end else begin
              raise = 1'b1; raise_code = 3'd1;
            end
          end
        endcase
      end
      S_STR: if (fire) begin
        if (in_data == 8'h22) begin
          emit         = 1'b1;
          e_kind       = K_STRING;
          e_data       = pend_valid_q ? pend_data_q : 8'h00;
          e_sop        = pend_first_q;
          e_empty      = !pend_valid_q;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else if (in_data < 8'h20) begin
          raise = 1'b1; raise_code = 3'd7;
        end else begin
          take = 1'b1;
          if (in_data == 8'h5C) state_d = S_ESC;
        end
      end
      S_ESC: if (fire) begin
        if (in_data < 8'h20) begin
          raise = 1'b1; raise_code = 3'd7;
        end else begin
          take    = 1'b1;
          state_d = S_STR;
        end
      end
      S_NUM: if (in_valid && slot) begin
        if (is_num_class(in_data)) begin
          take = 1'b1;
        end else begin
          emit         = 1'b1;
          e_kind       = K_NUMBER;
          e_data       = pend_data_q;
          e_sop        = pend_first_q;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_LIT: if (fire) begin
        if (in_data == lit_char(lit_sel_q, lit_idx_q)) begin
          if (lit_idx_q == ((lit_sel_q == 2'd1) ? 3'd4 : 3'd3)) begin
            emit    = 1'b1;
            e_kind  = (lit_sel_q == 2'd0) ? K_TRUE : (lit_sel_q == 2'd1) ? K_FALSE : K_NULL;
            state_d = S_IDLE;
          end else begin
            lit_idx_d = lit_idx_q + 3'd1;
          end
        end else begin
          raise = 1'b1; raise_code = 3'd2;
        end
      end
      S_FLUSH: if (slot) begin
        if (pend_valid_q) begin
          emit         = 1'b1;
          e_kind       = K_NUMBER;
          e_data       = pend_data_q;
          e_sop        = pend_first_q;
          pend_valid_d = 1'b0;
        end else if (unterm_q && !err_q) begin
          emit       = 1'b1;
          e_kind     = K_ERROR;
          e_data     = 8'd6;
          err_d      = 1'b1;
          err_code_d = 3'd6;
        end else begin
          emit     = 1'b1;
          e_kind   = K_EOD;
          depth_d  = '0;
          stack_d  = '0;
          unterm_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: ;  // S_ERR: bytes are dropped
    endcase

    // Payload byte: release the previously pending byte, park the new one.
    if (take) begin
      if (cnt_q >= CW'(MAX_TOKEN_LEN)) begin
        raise = 1'b1; raise_code = 3'd5;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (pend_valid_q) begin
          emit         = 1'b1;
          e_kind       = (state_q == S_NUM) ? K_NUMBER : K_STRING;
          e_data       = pend_data_q;
          e_sop        = pend_first_q;
          e_eop        = 1'b0;
          pend_first_d = 1'b0;
        end
        pend_valid_d = 1'b1;
        pend_data_d  = in_data;
      end
    end

    if (raise) begin
      emit         = 1'b1;
      e_kind       = K_ERROR;
      e_data       = {5'd0, raise_code};
      e_sop        = 1'b1;
      e_eop        = 1'b1;
      e_empty      = 1'b0;
      err_d        = 1'b1;
      err_code_d   = raise_code;
      pend_valid_d = 1'b0;
      state_d      = S_ERR;
    end

    // Last byte: any open string payload is abandoned, then FLUSH finishes up.
    if (fire && in_last) begin
      if (state_d == S_STR || state_d == S_ESC) pend_valid_d = 1'b0;
      unterm_d = (state_d == S_STR || state_d == S_ESC || state_d == S_LIT) ||
                 (depth_d != '0);
      state_d  = S_FLUSH;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_kind_d  = e_kind;
      out_data_d  = e_data;
      out_sop_d   = e_sop;
      out_eop_d   = e_eop;
      out_empty_d = e_empty;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 8'h00;
      pend_first_q <= 1'b0;
      cnt_q        <= '0;
      lit_sel_q    <= 2'd0;
      lit_idx_q    <= 3'd0;
      depth_q      <= '0;
      stack_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
      unterm_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_kind_q   <= 4'd0;
      out_data_q   <= 8'h00;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_first_q <= pend_first_d;
      cnt_q        <= cnt_d;
      lit_sel_q    <= lit_sel_d;
      lit_idx_q    <= lit_idx_d;
      depth_q      <= depth_d;
      stack_q      <= stack_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      unterm_q     <= unterm_d;
      out_valid_q  <= out_valid_d;
      out_kind_q   <= out_kind_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_json_byte_lexer.sv
// Directed bench for json_byte_lexer with small limits (max token 4, depth 2).
module tb_json_byte_lexer;
  localparam int MTL = 4;
  localparam int ND  = 2;
  localparam int DW  = $clog2(ND + 1);

  localparam logic [3:0] K_LBRACE = 4'd0,  K_RBRACE = 4'd1, K_LBRACK = 4'd2;
  localparam logic [3:0] K_RBRACK = 4'd3,  K_COLON  = 4'd4, K_COMMA  = 4'd5;
  localparam logic [3:0] K_STRING = 4'd6,  K_NUMBER = 4'd7, K_TRUE   = 4'd8;
  localparam logic [3:0] K_EOD    = 4'd11, K_ERROR  = 4'd15;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid, out_ready = 1'b1;
  logic [3:0]    out_kind;
  logic [7:0]    out_data;
  logic          out_sop, out_eop, out_empty, err;
  logic [2:0]    err_code;
  logic [DW-1:0] depth;

  json_byte_lexer #(.MAX_TOKEN_LEN(MTL), .NESTING_DEPTH(ND)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .err(err), .err_code(err_code), .depth(depth)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  int max_depth = 0;
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];

  // Beats are captured on the falling edge; out_ready only changes after rising edges.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back({out_kind, out_data, out_sop, out_eop, out_empty});
    if (int'(depth) > max_depth) max_depth = int'(depth);
  end

  function automatic logic [14:0] bt(input logic [3:0] k, input logic [7:0] d,
                                     input logic s, input logic e, input logic m);
    return {k, d, s, e, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: present one byte and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] b, input logic last);
    int n;
    in_valid = 1'b1; in_data = b; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1 for byte %0h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last && (i == s.len() - 1));
  endtask

  // Drain, then compare collected beats against the expected queue.
  task automatic check_beats(input string tag);
    int n;
    repeat (10) @(posedge clk);
    #1;
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_depth", depth, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: nested object / array with numbers
    max_depth = 0;
    send_str("{\"a\":[1,-2]}", 1'b1);
    exp_q.push_back(bt(K_LBRACE, 8'h7B, 1, 1, 0));
    exp_q.push_back(bt(K_STRING, 8'h61, 1, 1, 0));
    exp_q.push_back(bt(K_COLON,  8'h3A, 1, 1, 0));
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_NUMBER, 8'h31, 1, 1, 0));
    exp_q.push_back(bt(K_COMMA,  8'h2C, 1, 1, 0));
    exp_q.push_back(bt(K_NUMBER, 8'h2D, 1, 0, 0));
    exp_q.push_back(bt(K_NUMBER, 8'h32, 0, 1, 0));
    exp_q.push_back(bt(K_RBRACK, 8'h5D, 1, 1, 0));
    exp_q.push_back(bt(K_RBRACE, 8'h7D, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc1");
    check("doc1_max_depth", max_depth, 2);
    check("doc1_end_depth", depth, 0);
    check("doc1_err", err, 0);

    // 2: bad literal, remaining bytes dropped
    send_str("[true,nulx", 1'b0);
    check("doc2_err_set", err, 1);
    check("doc2_err_code", err_code, 2);
    send(8'h5D, 1'b1);
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_TRUE,   8'h00, 1, 1, 0));
    exp_q.push_back(bt(K_COMMA,  8'h2C, 1, 1, 0));
    exp_q.push_back(bt(K_ERROR,  8'h02, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc2");
    check("doc2_err_clear", err, 0);
    check("doc2_code_clear", err_code, 0);

    // 3: downstream stall during a string
    send(8'h22, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h63; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready%0d", i), in_ready, 0);
      check($sformatf("stall_hold%0d", i), {out_valid, out_data, out_sop}, {1'b1, 8'h61, 1'b1});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h63, 1'b0);
    send(8'h22, 1'b1);
    exp_q.push_back(bt(K_STRING, 8'h61, 1, 0, 0));
    exp_q.push_back(bt(K_STRING, 8'h62, 0, 0, 0));
    exp_q.push_back(bt(K_STRING, 8'h63, 0, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc3");

    // 4a: depth overflow on third '[' which is also the last byte
    send_str("[[[", 1'b1);
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_ERROR,  8'h03, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc4a");
    check("doc4a_depth", depth, 0);
    check("doc4a_err_clear", err, 0);

    // 4b: bracket mismatch
    send_str("[}", 1'b1);
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_ERROR,  8'h04, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc4b");

    // 4c: unterminated string
    send_str("\"ab", 1'b1);
    exp_q.push_back(bt(K_STRING, 8'h61, 1, 0, 0));
    exp_q.push_back(bt(K_ERROR,  8'h06, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc4c");

    // 5a: empty string
    send_str("\"\"", 1'b1);
    exp_q.push_back(bt(K_STRING, 8'h00, 1, 1, 1));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc5a");

    // 5b: escaped quote passes through raw
    send_str("\"\\\"\"", 1'b1);
    exp_q.push_back(bt(K_STRING, 8'h5C, 1, 0, 0));
    exp_q.push_back(bt(K_STRING, 8'h22, 0, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc5b");

    // 5c: token longer than the limit
    send_str("\"abcde\"", 1'b1);
    exp_q.push_back(bt(K_STRING, 8'h61, 1, 0, 0));
    exp_q.push_back(bt(K_STRING, 8'h62, 0, 0, 0));
    exp_q.push_back(bt(K_STRING, 8'h63, 0, 0, 0));
    exp_q.push_back(bt(K_ERROR,  8'h05, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc5c");

    // 6: reset in the middle of a string
    send_str("[\"ab", 1'b0);
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_STRING, 8'h61, 1, 0, 0));
    check_beats("doc6_pre");
    check("doc6_pre_depth", depth, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("doc6_rst_out_valid", out_valid, 0);
    check("doc6_rst_depth", depth, 0);
    send_str("[]", 1'b1);
    exp_q.push_back(bt(K_LBRACK, 8'h5B, 1, 1, 0));
    exp_q.push_back(bt(K_RBRACK, 8'h5D, 1, 1, 0));
    exp_q.push_back(bt(K_EOD,    8'h00, 1, 1, 0));
    check_beats("doc6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
